// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the round-robin arbiter family.
// State encodings and requester geometry reused by sequencing blocks.
package rr_arb8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters and the arbiter.
// The master side drives requests; the slave side is the arbiter.
interface rr_arb8_if;
  import rr_arb8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [0:NUM_REQ-1] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_arb8_dec.sv
// 3-to-8 one-hot decoder with enable.
// out[sel] is high only while en is high.
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [0:7] out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a bounded grant hold time.
// Each release costs one idle cycle before the next grant.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input logic    clk,
  input logic    reset,
  rr_arb8_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM =
    HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               to_q, to_d;
  logic [IDX_W-1:0]   pick;
  logic               cur_req;
  logic               lim;
  logic               rel;

  // First requester at or after p, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic [IDX_W-1:0] c;
    logic             hit;
    rr_pick = '0;
    hit     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = p + IDX_W'(k);
      if (!hit && r[c]) begin
        rr_pick = c;
        hit     = 1'b1;
      end
    end
  endfunction

  assign pick    = rr_pick(bus.req, ptr_q);
  assign cur_req = bus.req[idx_q];
  assign lim     = (hold_q == HOLD_LIM);
  assign rel     = bus.done | ~cur_req | lim;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d = ST_GRANT;
          idx_d   = pick;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          // Only a pure hold-limit release is reported.
          to_d    = lim & ~bus.done & cur_req;
        end else if (!lim) begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt_valid = (state_q == ST_GRANT);
  assign bus.gnt_idx   = idx_q;
  assign bus.timeout   = to_q;

  dec3to8 u_dec (
    .sel (idx_q),
    .en  (state_q == ST_GRANT),
    .out (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: vector table, directed corners,
// and random traffic against a cycle-level reference model.
module tb_rr_arb8;

  localparam int MH = 15;

  logic clk;
  logic reset;

  rr_arb8_if bus ();

  rr_arb8 #(
    .MAX_HOLD (MH),
    .HOLD_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // reference model state
  bit         m_busy;
  int         m_idx;
  int         m_ptr;
  bit         m_to;
  int         m_start;
  int         ecount;
  logic [7:0] prev_gnt;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       v;
    logic [2:0] idx;
    logic       to;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_idx    = 0;
    m_ptr    = 0;
    m_to     = 0;
    m_start  = 0;
    prev_gnt = '0;
  endtask

  task automatic model_edge();
    int  held;
    bit  d, dropped, lim;
    ecount++;
    if (reset) begin
      model_reset();
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      if (bus.req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (bus.req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy  = 1;
        m_start = ecount;
      end
    end else begin
      held    = ecount - 1 - m_start;
      d       = bus.done;
      dropped = !bus.req[m_idx];
      lim     = (held >= MH - 1);
      if (d || dropped || lim) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        m_to   = lim && !d && !dropped;
      end
    end
  endtask

  task automatic step();
    logic [0:7] e;
    logic [7:0] cur;
    model_edge();
    @(posedge clk);
    #1;
    e = '0;
    if (m_busy) e[m_idx] = 1'b1;
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
    chk("gnt", 32'(bus.gnt), 32'(e));
    cur = bus.gnt;
    chk("onehot", 32'($countones(cur) > 1), 32'(0));
    chk("adjacent",
        32'(prev_gnt != 0 && cur != 0 && prev_gnt != cur),
        32'(0));
    prev_gnt = cur;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    ecount   = 0;
    model_reset();

    // 1: reset held with no requests
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_gnt", 32'(bus.gnt), 32'(0));
      chk("rst_valid", 32'(bus.gnt_valid), 32'(0));
      chk("rst_to", 32'(bus.timeout), 32'(0));
    end
    reset = 1'b0;

    // 2 + 5b: table of vectors from ptr=0
    tbl[0] = '{8'h24, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[1] = '{8'h24, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[2] = '{8'h24, 1'b0, 1'b1, 3'd5, 1'b0};
    tbl[3] = '{8'h24, 1'b1, 1'b0, 3'd5, 1'b0};
    tbl[4] = '{8'h24, 1'b0, 1'b1, 3'd2, 1'b0};
    tbl[5] = '{8'h20, 1'b0, 1'b0, 3'd2, 1'b0};
    tbl[6] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 3'd5, 1'b0};
    tbl[8] = '{8'h00, 1'b1, 1'b0, 3'd5, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      step();
      chk($sformatf("tbl%0d_valid", i),
          32'(bus.gnt_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_idx", i),
          32'(bus.gnt_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_to", i),
          32'(bus.timeout), 32'(tbl[i].to));
    end
    bus.done = 1'b0;

    // 3: all requesting, done pulsed each grant
    do_reset();
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step();
      chk("rr_valid", 32'(bus.gnt_valid), 32'(1));
      chk("rr_order", 32'(bus.gnt_idx), 32'(g % 8));
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("rr_dead", 32'(bus.gnt_valid), 32'(0));
    end

    // 4: lone requester held to the limit
    do_reset();
    bus.req = 8'h08;
    step();
    cnt = 0;
    while (bus.gnt_valid && cnt < 40) begin
      cnt++;
      step();
    end
    chk("hold_len", 32'(cnt), 32'(MH));
    chk("hold_to", 32'(bus.timeout), 32'(1));
    chk("hold_gnt0", 32'(bus.gnt), 32'(0));
    step();
    chk("regrant_v", 32'(bus.gnt_valid), 32'(1));
    chk("regrant_i", 32'(bus.gnt_idx), 32'(3));
    chk("regrant_to", 32'(bus.timeout), 32'(0));

    // 5a: done coincides with the hold limit
    do_reset();
    bus.req = 8'h08;
    step();
    repeat (MH - 1) step();
    chk("lim_still", 32'(bus.gnt_valid), 32'(1));
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("lim_done_v", 32'(bus.gnt_valid), 32'(0));
    chk("lim_done_to", 32'(bus.timeout), 32'(0));

    // 6: asynchronous reset mid-grant
    do_reset();
    bus.req = 8'h10;
    step();
    chk("pre_rst_v", 32'(bus.gnt_valid), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_v", 32'(bus.gnt_valid), 32'(0));
    chk("arst_gnt", 32'(bus.gnt), 32'(0));
    model_reset();
    #1;
    reset   = 1'b0;
    bus.req = 8'h81;
    step();
    chk("post_rst_i", 32'(bus.gnt_idx), 32'(0));
    chk("post_rst_v", 32'(bus.gnt_valid), 32'(1));

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0)
          bus.req = 8'($urandom) & 8'($urandom);
        else
          bus.req = 8'($urandom);
      end
      bus.done = ($urandom_range(0, 9) == 0);
      step();
    end
    bus.done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
